tst_din_chk: RTL and testbench

- Loopback checker that sits directly downstream of the test-data FIFO fed by tst_din_dgen.
- Pops 64-bit words and regenerates the expected stream with the same PRBS31 seeds and the same word packing.
- Compares word by word and reports done, pass and error statistics for one iteration of 4 FFTs (2^16 words).

---
 rtl/tst_din_pkg.sv | 23 ++
 rtl/tst_din_chk_exp.sv | 23 ++
 rtl/tst_din_dgen_prbs31.sv | 22 ++
 rtl/tst_din_chk.sv | 122 ++++++++++++
 tb/tb_tst_din_chk.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/tst_din_pkg.sv
// rtl/tst_din_pkg.sv - shared constants, checker states and word packing for tst_din_dgen / tst_din_chk
package tst_din_pkg;
  localparam int WORD_W          = 64;
  localparam int SAMPLE_W        = 28;
  localparam logic [3:0] HDR_NIB = 4'd8;
  localparam int NWORDS_LOG2_DEF = 16;

  typedef enum logic [1:0] {CHK_IDLE, CHK_RUN, CHK_DONE} chk_state_t;

  // Each 32-bit lane is {sample msb, header nibble, sample[26:0]}; imaginary lane on top.
  function automatic logic [WORD_W-1:0] pack(input logic [SAMPLE_W-1:0] re,
                                             input logic [SAMPLE_W-1:0] im);
    return {im[SAMPLE_W-1], HDR_NIB, im[SAMPLE_W-2:0], re[SAMPLE_W-1], HDR_NIB, re[SAMPLE_W-2:0]};
  endfunction

  // x^31 + x^28 + 1, stepped once per sample bit so each sample is fresh sequence bits.
  function automatic logic [30:0] prbs31_adv(input logic [30:0] s);
    logic [30:0] t;
    t = s;
    for (int i = 0; i < SAMPLE_W; i++) t = {t[29:0], t[30] ^ t[27]};
    return t;
  endfunction
endpackage

// File: rtl/tst_din_chk_exp.sv
// rtl/tst_din_chk_exp.sv - regenerates the expected generator word stream for the checker
module tst_din_chk_exp import tst_din_pkg::*; #(
  parameter logic [63:0] SEED = 64'h1234589abcdef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [WORD_W-1:0] exp_word,
  output logic              exp_valid
);
  logic [SAMPLE_W-1:0] re_s;
  logic [SAMPLE_W-1:0] im_s;

  tst_din_dgen_prbs31 #(.SEED(SEED[31:0])) u_re (.clk(clk), .rst(rst), .en(en), .sample(re_s));
  tst_din_dgen_prbs31 #(.SEED(SEED[63:32])) u_im (.clk(clk), .rst(rst), .en(en), .sample(im_s));

  always_ff @(posedge clk) begin
    if (rst) exp_valid <= 1'b0;
    else     exp_valid <= en;
  end

  assign exp_word = pack(re_s, im_s);
endmodule

// File: rtl/tst_din_dgen_prbs31.sv
// rtl/tst_din_dgen_prbs31.sv - one PRBS31 lane emitting a 28-bit sample per enable
module tst_din_dgen_prbs31 import tst_din_pkg::*; #(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [SAMPLE_W-1:0] sample
);
  logic [30:0] state;

  // sample is the pre-advance state, so it appears the cycle after en
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SEED[30:0];
      sample <= '0;
    end else if (en) begin
      state  <= prbs31_adv(state);
      sample <= state[SAMPLE_W-1:0];
    end
  end
endmodule

// File: rtl/tst_din_chk.sv
// rtl/tst_din_chk.sv - loopback checker for the test-data FIFO; TST_DIN_CHK_ERRCAP_EN adds first-error capture
module tst_din_chk import tst_din_pkg::*; #(
  parameter logic [63:0] rini        = 64'h1234589abcdef,
  parameter int          NWORDS_LOG2 = NWORDS_LOG2_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   fifo_empty,
  output logic                   fifo_re,
  input  logic [WORD_W-1:0]      fifo_rd,
  output logic                   done,
  output logic                   pass,
  output logic [31:0]            err_cnt,
  output logic [NWORDS_LOG2-1:0] first_err_idx,
  output logic                   err_seen
`ifdef TST_DIN_CHK_ERRCAP_EN
  ,
  output logic [WORD_W-1:0]      err_exp,
  output logic [WORD_W-1:0]      err_got
`endif
);
  localparam logic [NWORDS_LOG2:0] NWORDS = {1'b1, {NWORDS_LOG2{1'b0}}};

  chk_state_t           state, state_d;
  logic [1:0]           rst_sync;
  logic                 prbs_rst;
  logic [NWORDS_LOG2:0] issued;
  logic [NWORDS_LOG2:0] cmp_cnt;
  logic [WORD_W-1:0]    exp_word;
  logic                 exp_valid;
  logic                 cmp_en;
  logic                 mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // start reseeds and also drops the pipeline valid of any read in flight
  assign prbs_rst = ~rst_sync[1] | start;

  tst_din_chk_exp #(.SEED(rini)) u_exp (
    .clk      (clk),
    .rst      (prbs_rst),
    .en       (fifo_re),
    .exp_word (exp_word),
    .exp_valid(exp_valid)
  );

  assign cmp_en   = exp_valid & (state == CHK_RUN) & ~start;
  assign mismatch = exp_word != fifo_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CHK_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    fifo_re = 1'b0;
    done    = 1'b1;
    pass    = 1'b0;
    case (state)
      CHK_IDLE: if (start) state_d = CHK_RUN;
      CHK_RUN: begin
        done    = 1'b0;
        fifo_re = ~fifo_empty & ~issued[NWORDS_LOG2];
        if (start)                 state_d = CHK_RUN;
        else if (cmp_cnt == NWORDS) state_d = CHK_DONE;
      end
      CHK_DONE: begin
        pass = (err_cnt == 32'd0);
        if (start) state_d = CHK_RUN;
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued        <= '0;
      cmp_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      err_seen      <= 1'b0;
    end else if (start) begin
      issued        <= '0;
      cmp_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      err_seen      <= 1'b0;
    end else begin
      if (fifo_re) issued <= issued + (NWORDS_LOG2 + 1)'(1);
      if (cmp_en) begin
        cmp_cnt <= cmp_cnt + (NWORDS_LOG2 + 1)'(1);
        if (mismatch) begin
          if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
          if (!err_seen) begin
            err_seen      <= 1'b1;
            first_err_idx <= cmp_cnt[NWORDS_LOG2-1:0];
          end
        end
      end
    end
  end

`ifdef TST_DIN_CHK_ERRCAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_exp <= '0;
      err_got <= '0;
    end else if (start) begin
      err_exp <= '0;
      err_got <= '0;
    end else if (cmp_en && mismatch && !err_seen) begin
      err_exp <= exp_word;
      err_got <= fifo_rd;
    end
  end
`endif
endmodule

// File: tb/tb_tst_din_chk.sv
// tb/tb_tst_din_chk.sv - self-checking bench for tst_din_chk against a PRBS-sequence model
module tb_tst_din_chk;
  localparam int LOG2 = 10;
  localparam int N    = 1 << LOG2;
  localparam int M    = 2 * N;
  localparam logic [63:0] SEED = 64'h1234589abcdef;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic fifo_empty, fifo_re, done, pass, err_seen;
  logic [63:0] fifo_rd;
  logic [31:0] err_cnt;
  logic [LOG2-1:0] first_err_idx;
`ifdef TST_DIN_CHK_ERRCAP_EN
  logic [63:0] err_exp, err_got;
`endif

  logic [63:0] mdl [M];
  logic [63:0] src [M];
  int rd_ptr;
  logic thr = 1'b0;
  logic thr_en = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  // scoreboard state for the current run
  int pq[$];
  int vis, errs, first, mode, last_pop;
  logic [63:0] cap_exp, cap_got;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tst_din_chk #(.rini(SEED), .NWORDS_LOG2(LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_rd(fifo_rd), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .err_seen(err_seen)
`ifdef TST_DIN_CHK_ERRCAP_EN
    , .err_exp(err_exp), .err_got(err_got)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
    end
  endtask

  // Words from the sequence recurrence x[n] = x[n-31] ^ x[n-28]; sample w bit i = x[28w-i].
  task automatic gen_model();
    bit xr[];
    bit xi[];
    logic [27:0] r, im;
    logic [63:0] sd;
    int len;
    sd  = SEED;
    len = 28 * M + 31;
    xr  = new[len];
    xi  = new[len];
    for (int i = 0; i < 31; i++) begin
      xr[30 - i] = sd[i];
      xi[30 - i] = sd[32 + i];
    end
    for (int k = 31; k < len; k++) begin
      xr[k] = xr[k - 31] ^ xr[k - 28];
      xi[k] = xi[k - 31] ^ xi[k - 28];
    end
    for (int w = 0; w < M; w++) begin
      for (int b = 0; b < 28; b++) begin
        r[b]  = xr[28 * w - b + 30];
        im[b] = xi[28 * w - b + 30];
      end
      mdl[w] = {im[27], 4'h8, im[26:0], r[27], 4'h8, r[26:0]};
    end
  endtask

  task automatic load_clean();
    for (int i = 0; i < M; i++) src[i] = mdl[i];
  endtask

  // FIFO model: read data registered, generator restarts with the checker
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= 0;
      fifo_rd <= '0;
    end else begin
      if (fifo_re) fifo_rd <= src[rd_ptr];
      if (start)        rd_ptr <= 0;
      else if (fifo_re) rd_ptr <= rd_ptr + 1;
    end
  end
  assign fifo_empty = thr | (rd_ptr >= M);

  initial forever begin
    @(posedge clk);
    #1 thr = thr_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mode = 0; pq.delete(); vis = 0; errs = 0; first = 0; cap_exp = '0; cap_got = '0;
    end else begin
      while (vis < pq.size() && vis < M && pq[vis] <= cyc - 2) begin
        if (src[vis] !== mdl[vis]) begin
          if (errs == 0) begin
            first = vis; cap_exp = mdl[vis]; cap_got = src[vis];
          end
          errs++;
        end
        vis++;
      end
      if (mode == 1 && pq.size() == N && cyc >= pq[N - 1] + 3) mode = 2;
      chk("fifo_re", fifo_re, mode == 1 && !fifo_empty && pq.size() < N);
      chk("done", done, mode != 1);
      chk("pass", pass, mode == 2 && errs == 0);
      chk("err_cnt", err_cnt, errs);
      chk("err_seen", err_seen, errs != 0);
      chk("first_err_idx", first_err_idx, first);
`ifdef TST_DIN_CHK_ERRCAP_EN
      chk("err_exp", err_exp, cap_exp);
      chk("err_got", err_got, cap_got);
`endif
      if (fifo_re && pq.size() < M) begin
        pq.push_back(cyc);
        last_pop = cyc;
      end
      if (start) begin
        mode = 1; pq.delete(); vis = 0; errs = 0; first = 0; cap_exp = '0; cap_got = '0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", done, 1'b1);
    dcyc = cyc;
  endtask

  initial begin
    int d, k;
    gen_model();
    load_clean();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_done", done, 1'b1);
    chk("rst_pass", pass, 1'b0);
    chk("rst_fifo_re", fifo_re, 1'b0);
    chk("rst_err_cnt", err_cnt, 32'd0);
    chk("rst_err_seen", err_seen, 1'b0);
    chk("rst_first_err_idx", first_err_idx, '0);
    chk("model_word0", mdl[0], 64'h40012345_C1ABCDEF);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    pulse_start();
    wait_done(4 * N + 50, d);
    chk("clean_pass", pass, 1'b1);
    chk("clean_err_cnt", err_cnt, 32'd0);

    src[1000] = src[1000] ^ 64'h20;
    pulse_start();
    wait_done(4 * N + 50, d);
    chk("single_pass", pass, 1'b0);
    chk("single_err_cnt", err_cnt, 32'd1);
    chk("single_first_idx", first_err_idx, 10'd1000);
    chk("single_err_seen", err_seen, 1'b1);
`ifdef TST_DIN_CHK_ERRCAP_EN
    chk("single_cap_xor", err_got ^ err_exp, 64'h20);
`endif

    load_clean();
    src[10][30:27] = 4'd0;
    src[20][30:27] = 4'd0;
    pulse_start();
    wait_done(4 * N + 50, d);
    chk("hdr_err_cnt", err_cnt, 32'd2);
    chk("hdr_first_idx", first_err_idx, 10'd10);
    chk("hdr_pass", pass, 1'b0);

    load_clean();
    thr_en = 1'b1;
    pulse_start();
    wait_done(12 * N, d);
    thr_en = 1'b0;
    chk("thr_pass", pass, 1'b1);
    chk("thr_done_latency", d - last_pop, 3);

    pulse_start();
    k = 0;
    while (pq.size() < 600 && k < 4 * N) begin
      @(negedge clk);
      k++;
    end
    chk("restart_reached", pq.size() >= 600, 1'b1);
    pulse_start();
    wait_done(4 * N + 50, d);
    chk("restart_pass", pass, 1'b1);
    chk("restart_err_cnt", err_cnt, 32'd0);

    src[10] = src[10] ^ 64'h20;
    pulse_start();
    repeat (100) @(negedge clk);
    chk("pre_reset_err_cnt", err_cnt, 32'd1);
    chk("pre_reset_done", done, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_done", done, 1'b1);
    chk("async_fifo_re", fifo_re, 1'b0);
    chk("async_err_cnt", err_cnt, 32'd0);
    chk("async_err_seen", err_seen, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_done", done, 1'b1);
    chk("post_reset_pass", pass, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
